// File: rtl/norm_pkg.sv
// Shared widths, requester ids and pipeline record types for the normalizing scheduler.
package norm_pkg;

    localparam int DW  = 48;
    localparam int LZW = 6;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] data;
    } s1_t;

    typedef struct packed {
        logic           id;
        logic [LZW-1:0] lz;
        logic [DW-1:0]  mant;
        logic           zero;
    } res_t;

    // A shift of DW on an all-zero operand still yields zero, so no special case is needed.
    function automatic logic [DW-1:0] norm_shift(input logic [DW-1:0] d, input logic [LZW-1:0] lz);
        return d << lz;
    endfunction

endpackage

// File: rtl/norm_sched_if.sv
// Two requester handshakes plus the normalized-result handshake of norm_sched.
interface norm_sched_if;
    import norm_pkg::*;

    logic           a_valid;
    logic           a_ready;
    logic [DW-1:0]  a_data;
    logic           b_valid;
    logic           b_ready;
    logic [DW-1:0]  b_data;
    logic           out_valid;
    logic           out_ready;
    logic           out_id;
    logic [LZW-1:0] out_lz;
    logic [DW-1:0]  out_mant;
    logic           out_zero;

    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, out_valid, out_id, out_lz, out_mant, out_zero
    );

    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, out_valid, out_id, out_lz, out_mant, out_zero
    );

endinterface

// File: rtl/norm_sched_lzd.sv
// 48-bit leading-zero detector; an all-zero input reports DW.
module lzd
    import norm_pkg::*;
(
    input  logic [DW-1:0]  din,
    output logic [LZW-1:0] cnt
);

    localparam int NN = DW / 4;

    logic [NN-1:0] nib_nz;
    logic [1:0]    nib_lz [NN];

    for (genvar gi = 0; gi < NN; gi++) begin : g_nib
        logic [3:0] nib;
        assign nib        = din[gi*4 +: 4];
        assign nib_nz[gi] = |nib;
        assign nib_lz[gi] = nib[3] ? 2'd0 :
                            nib[2] ? 2'd1 :
                            nib[1] ? 2'd2 : 2'd3;
    end

    // Scan from the least significant nibble so the most significant non-zero one wins.
    always_comb begin
        cnt = LZW'(DW);
        for (int k = 0; k < NN; k++) begin
            if (nib_nz[k]) begin
                cnt = LZW'((NN - 1 - k) * 4) + LZW'(nib_lz[k]);
            end
        end
    end

endmodule

// File: rtl/norm_sched.sv
// Two-stage scheduler sharing one leading-zero normalizer between requesters A and B.
module norm_sched
    import norm_pkg::*;
#(
    parameter bit FAIR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    norm_sched_if.slave bus
);

    logic           s1_valid_q, s1_valid_d;
    s1_t            s1_q, s1_d;
    logic           ptr_q, ptr_d;
    logic           init_q;
    logic           out_valid_q, out_valid_d;
    res_t           out_q, out_d;

    logic [LZW-1:0] lz;
    logic           s2_load;
    logic           s1_load;
    logic           gnt_a, gnt_b;
    logic           acc_a, acc_b;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (FAIR_EN) begin
            if (bus.a_valid && bus.b_valid) begin
                gnt_a = (ptr_q == ID_B);
                gnt_b = (ptr_q == ID_A);
            end else begin
                gnt_a = bus.a_valid;
                gnt_b = bus.b_valid;
            end
        end else begin
            gnt_a = bus.a_valid;
            gnt_b = bus.b_valid & ~bus.a_valid;
        end
    end

    // init_q keeps both readies low until the first edge after reset release.
    assign s2_load     = ~out_valid_q | bus.out_ready;
    assign s1_load     = init_q & (~s1_valid_q | s2_load);
    assign bus.a_ready = s1_load & gnt_a;
    assign bus.b_ready = s1_load & gnt_b;
    assign acc_a       = bus.a_valid & bus.a_ready;
    assign acc_b       = bus.b_valid & bus.b_ready;

    lzd u_lzd (
        .din (s1_q.data),
        .cnt (lz)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        ptr_d      = ptr_q;
        if (s1_load) begin
            s1_valid_d = acc_a | acc_b;
        end
        if (acc_a) begin
            s1_d.id   = ID_A;
            s1_d.data = bus.a_data;
            ptr_d     = ID_A;
        end else if (acc_b) begin
            s1_d.id   = ID_B;
            s1_d.data = bus.b_data;
            ptr_d     = ID_B;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d.id   = s1_q.id;
                out_d.lz   = lz;
                out_d.mant = norm_shift(s1_q.data, lz);
                out_d.zero = ~|s1_q.data;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            ptr_q       <= ID_B;
            init_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            ptr_q       <= ptr_d;
            init_q      <= 1'b1;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_id    = out_q.id;
    assign bus.out_lz    = out_q.lz;
    assign bus.out_mant  = out_q.mant;
    assign bus.out_zero  = out_q.zero;

    a_one_ready: assert property (@(posedge clk) disable iff (!rstn)
        !(bus.a_ready && bus.b_ready));

    a_out_hold: assert property (@(posedge clk) disable iff (!rstn)
        (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.out_mant) && $stable(bus.out_lz)));

endmodule

// File: tb/tb_norm_sched.sv
// Directed bench for norm_sched: stimulus pushes expected results, per-DUT monitors pop and compare.
module tb_norm_sched;
    import norm_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    norm_sched_if bus_f ();
    norm_sched_if bus_p ();

    norm_sched #(.FAIR_EN(1'b1)) dut_f (.clk(clk), .rstn(rstn), .bus(bus_f.slave));
    norm_sched #(.FAIR_EN(1'b0)) dut_p (.clk(clk), .rstn(rstn), .bus(bus_p.slave));

    int errors = 0;
    int checks = 0;

    logic [DW-1:0]  tbl      [8] = '{48'h8000_0000_0000, 48'h0000_0000_0001, 48'h0000_0001_0000,
                                     48'h0123_4567_89AB, 48'h0000_0000_0000, 48'h00F0_0000_0000,
                                     48'h7FFF_FFFF_FFFF, 48'h0000_8000_0001};
    logic [LZW-1:0] exp_lz   [8] = '{6'd0, 6'd47, 6'd31, 6'd7, 6'd48, 6'd8, 6'd1, 6'd16};
    logic [DW-1:0]  exp_mant [8] = '{48'h8000_0000_0000, 48'h8000_0000_0000, 48'h8000_0000_0000,
                                     48'h91A2_B3C4_D580, 48'h0000_0000_0000, 48'hF000_0000_0000,
                                     48'hFFFF_FFFF_FFFE, 48'h8000_0001_0000};
    logic           exp_zero [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    res_t q_f [$];
    res_t q_p [$];

    logic [2:0] a_cnt_f, b_cnt_f, a_cnt_p, b_cnt_p;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic res_t mk_exp(input logic id, input logic [2:0] idx);
        res_t r;
        r.id   = id;
        r.lz   = exp_lz[idx];
        r.mant = exp_mant[idx];
        r.zero = exp_zero[idx];
        return r;
    endfunction

    // One cycle of stimulus; gnt codes are 0 = none, 1 = A, 2 = B.
    task automatic step(input logic av, input logic bv, input logic ordy,
                        output logic [1:0] gf, output logic [1:0] gp);
        @(negedge clk);
        bus_f.a_valid = av;  bus_f.a_data = tbl[a_cnt_f];
        bus_f.b_valid = bv;  bus_f.b_data = tbl[b_cnt_f];
        bus_f.out_ready = ordy;
        bus_p.a_valid = av;  bus_p.a_data = tbl[a_cnt_p];
        bus_p.b_valid = bv;  bus_p.b_data = tbl[b_cnt_p];
        bus_p.out_ready = ordy;
        #1;
        chk("one_ready_f", {63'd0, bus_f.a_ready & bus_f.b_ready}, 64'd0);
        chk("one_ready_p", {63'd0, bus_p.a_ready & bus_p.b_ready}, 64'd0);
        gf = 2'd0;
        gp = 2'd0;
        if (av && bus_f.a_ready) begin
            gf = 2'd1; q_f.push_back(mk_exp(ID_A, a_cnt_f)); a_cnt_f++;
        end else if (bv && bus_f.b_ready) begin
            gf = 2'd2; q_f.push_back(mk_exp(ID_B, b_cnt_f)); b_cnt_f++;
        end
        if (av && bus_p.a_ready) begin
            gp = 2'd1; q_p.push_back(mk_exp(ID_A, a_cnt_p)); a_cnt_p++;
        end else if (bv && bus_p.b_ready) begin
            gp = 2'd2; q_p.push_back(mk_exp(ID_B, b_cnt_p)); b_cnt_p++;
        end
        if (gf != 2'd0 || gp != 2'd0)
            $display("[%0t] accept f=%0d p=%0d", $time, gf, gp);
    endtask

    task automatic idle(input int n);
        logic [1:0] gf, gp;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, gf, gp);
    endtask

    task automatic set_valids(input logic v);
        bus_f.a_valid = v; bus_f.b_valid = v;
        bus_p.a_valid = v; bus_p.b_valid = v;
    endtask

    initial begin : mon_f
        res_t act, held_v, e;
        logic held;
        held = 1'b0;
        held_v = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rstn) begin
                held = 1'b0;
            end else begin
                act = '{id: bus_f.out_id, lz: bus_f.out_lz, mant: bus_f.out_mant, zero: bus_f.out_zero};
                if (held) begin
                    chk("hold_valid_f", {63'd0, bus_f.out_valid}, 64'd1);
                    chk("hold_data_f", 64'(act), 64'(held_v));
                end
                held   = bus_f.out_valid & ~bus_f.out_ready;
                held_v = act;
                if (bus_f.out_valid && bus_f.out_ready) begin
                    if (q_f.size() == 0) begin
                        chk("unexpected_out_f", 64'(act), 64'd0);
                    end else begin
                        e = q_f.pop_front();
                        chk("result_f", 64'(act), 64'(e));
                        $display("[%0t] out f id=%0d lz=%0d mant=%h", $time, act.id, act.lz, act.mant);
                    end
                end
            end
        end
    end

    initial begin : mon_p
        res_t act, held_v, e;
        logic held;
        held = 1'b0;
        held_v = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rstn) begin
                held = 1'b0;
            end else begin
                act = '{id: bus_p.out_id, lz: bus_p.out_lz, mant: bus_p.out_mant, zero: bus_p.out_zero};
                if (held) begin
                    chk("hold_valid_p", {63'd0, bus_p.out_valid}, 64'd1);
                    chk("hold_data_p", 64'(act), 64'(held_v));
                end
                held   = bus_p.out_valid & ~bus_p.out_ready;
                held_v = act;
                if (bus_p.out_valid && bus_p.out_ready) begin
                    if (q_p.size() == 0) begin
                        chk("unexpected_out_p", 64'(act), 64'd0);
                    end else begin
                        e = q_p.pop_front();
                        chk("result_p", 64'(act), 64'(e));
                        $display("[%0t] out p id=%0d lz=%0d mant=%h", $time, act.id, act.lz, act.mant);
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [1:0] gf, gp;
        logic [1:0] bp_f [5] = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
        logic [1:0] bp_p [5] = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
        int acc_f;

        rstn = 1'b0;
        a_cnt_f = '0; b_cnt_f = '0; a_cnt_p = '0; b_cnt_p = '0;
        bus_f.a_data = '0; bus_f.b_data = '0; bus_f.out_ready = 1'b1;
        bus_p.a_data = '0; bus_p.b_data = '0; bus_p.out_ready = 1'b1;
        set_valids(1'b0);

        // Reset state, with requests pending so ready must be actively held low.
        @(negedge clk);
        set_valids(1'b1);
        #1;
        chk("rst_a_ready_f", {63'd0, bus_f.a_ready}, 64'd0);
        chk("rst_b_ready_f", {63'd0, bus_f.b_ready}, 64'd0);
        chk("rst_a_ready_p", {63'd0, bus_p.a_ready}, 64'd0);
        chk("rst_out_valid_f", {63'd0, bus_f.out_valid}, 64'd0);
        chk("rst_out_valid_p", {63'd0, bus_p.out_valid}, 64'd0);
        chk("rst_out_id", {63'd0, bus_f.out_id}, 64'd0);
        chk("rst_out_lz", {58'd0, bus_f.out_lz}, 64'd0);
        chk("rst_out_mant", {16'd0, bus_f.out_mant}, 64'd0);
        chk("rst_out_zero", {63'd0, bus_f.out_zero}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rel_a_ready_f", {63'd0, bus_f.a_ready}, 64'd0);
        chk("rel_a_ready_p", {63'd0, bus_p.a_ready}, 64'd0);
        set_valids(1'b0);

        // Single A with latency check.
        a_cnt_f = 3'd2; a_cnt_p = 3'd2;
        step(1'b1, 1'b0, 1'b1, gf, gp);
        chk("single_a_gnt_f", {62'd0, gf}, 64'd1);
        chk("single_a_gnt_p", {62'd0, gp}, 64'd1);
        step(1'b0, 1'b0, 1'b1, gf, gp);
        chk("lat_c1_f", {63'd0, bus_f.out_valid}, 64'd0);
        step(1'b0, 1'b0, 1'b1, gf, gp);
        chk("lat_c2_f", {63'd0, bus_f.out_valid}, 64'd1);
        chk("lat_c2_p", {63'd0, bus_p.out_valid}, 64'd1);
        idle(1);

        // B with zero operand, then B with MSB set.
        b_cnt_f = 3'd4; b_cnt_p = 3'd4;
        step(1'b0, 1'b1, 1'b1, gf, gp);
        chk("b_zero_gnt_f", {62'd0, gf}, 64'd2);
        chk("b_zero_gnt_p", {62'd0, gp}, 64'd2);
        idle(2);
        b_cnt_f = 3'd0; b_cnt_p = 3'd0;
        step(1'b0, 1'b1, 1'b1, gf, gp);
        chk("b_msb_gnt_f", {62'd0, gf}, 64'd2);
        idle(3);
        chk("q_empty1_f", 64'(q_f.size()), 64'd0);
        chk("q_empty1_p", 64'(q_p.size()), 64'd0);

        // Both requesters streaming: fair alternation vs fixed priority.
        a_cnt_f = 3'd0; b_cnt_f = 3'd3; a_cnt_p = 3'd0; b_cnt_p = 3'd3;
        acc_f = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b1, gf, gp);
            chk("fair_gnt_f", {62'd0, gf}, (i % 2 == 0) ? 64'd1 : 64'd2);
            chk("prio_gnt_p", {62'd0, gp}, 64'd1);
            if (gf != 2'd0) acc_f++;
        end
        chk("fair_tput_f", 64'(acc_f), 64'd8);
        idle(3);
        chk("q_empty2_f", 64'(q_f.size()), 64'd0);
        chk("q_empty2_p", 64'(q_p.size()), 64'd0);

        // Backpressure: two accepts fill S1/S2, then ready stays low.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, gf, gp);
            chk("bp_gnt_f", {62'd0, gf}, {62'd0, bp_f[i]});
            chk("bp_gnt_p", {62'd0, gp}, {62'd0, bp_p[i]});
        end
        chk("bp_out_valid_f", {63'd0, bus_f.out_valid}, 64'd1);
        idle(4);
        chk("q_empty3_f", 64'(q_f.size()), 64'd0);
        chk("q_empty3_p", 64'(q_p.size()), 64'd0);

        // Reset with both stages full.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, gf, gp);
        @(negedge clk);
        set_valids(1'b0);
        rstn = 1'b0;
        #1;
        chk("mid_rst_out_valid_f", {63'd0, bus_f.out_valid}, 64'd0);
        chk("mid_rst_out_valid_p", {63'd0, bus_p.out_valid}, 64'd0);
        chk("mid_rst_lz_f", {58'd0, bus_f.out_lz}, 64'd0);
        q_f.delete();
        q_p.delete();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        set_valids(1'b1);
        #1;
        chk("mid_rel_a_ready_f", {63'd0, bus_f.a_ready}, 64'd0);
        chk("mid_rel_b_ready_f", {63'd0, bus_f.b_ready}, 64'd0);
        set_valids(1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, gf, gp);
            chk("no_stale_f", {63'd0, bus_f.out_valid}, 64'd0);
            chk("no_stale_p", {63'd0, bus_p.out_valid}, 64'd0);
        end
        step(1'b1, 1'b1, 1'b1, gf, gp);
        chk("restart_gnt_f", {62'd0, gf}, 64'd1);
        chk("restart_gnt_p", {62'd0, gp}, 64'd1);
        step(1'b1, 1'b1, 1'b1, gf, gp);
        chk("restart_gnt2_f", {62'd0, gf}, 64'd2);
        idle(3);
        chk("q_empty4_f", 64'(q_f.size()), 64'd0);
        chk("q_empty4_p", 64'(q_p.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
